// File: rtl/operand_fetch_stage_if.sv
// Handshake bundles around the operand fetch stage.
//   fetch_if : fetch -> stage. master = fetch unit, slave = operand fetch stage.
//              in_valid/in_instr/in_pc flow downstream, in_ready flows back.
//   exec_if  : stage -> execute. master = operand fetch stage, slave = execute.
//              out_valid and the latched instruction fields flow downstream,
//              out_ready flows back.

interface fetch_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [DATA_W-1:0] in_pc;

  modport master (output in_valid, output in_instr, output in_pc, input in_ready);
  modport slave  (input in_valid, input in_instr, input in_pc, output in_ready);
endinterface

interface exec_if #(
  parameter int DATA_W = 16,
  parameter int RIDX_W = 4
);
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_opcode;
  logic [RIDX_W-1:0] out_rd;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [DATA_W-1:0] out_pc;

  modport master (output out_valid, output out_opcode, output out_rd, output out_a,
                  output out_b, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_opcode, input out_rd, input out_a,
                  input out_b, input out_pc, output out_ready);
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage sitting directly upstream of the 16x16 register file.
// Splits the incoming instruction into register read addresses, captures both
// read operands (with writeback bypass) into a one-entry valid/ready register
// feeding execute, and stalls fetch on a load-use hazard.
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   fetch (fetch_if.slave)  in_valid/in_ready/in_instr/in_pc from fetch
//   exec  (exec_if.master)  out_valid/out_ready/opcode/rd/a/b/pc to execute
//   rf_reg1, rf_reg2        register file read addresses (from in_instr rs/rt)
//   rf_read1, rf_read2      register file read data (combinational)
//   wb_w_flag, wb_write_code, wb_w_data  writeback port (same as RF write)
//   ex_load_valid, ex_load_rd            load currently in execute
//   flush                   squash held and incoming instruction

module operand_fetch_stage #(
  parameter int DATA_W    = 16,
  parameter int RIDX_W    = 4,
  parameter int BYPASS_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  fetch_if.slave            fetch,
  exec_if.master            exec,
  output logic [DATA_W-1:0] rf_reg1,
  output logic [DATA_W-1:0] rf_reg2,
  input  logic [DATA_W-1:0] rf_read1,
  input  logic [DATA_W-1:0] rf_read2,
  input  logic              wb_w_flag,
  input  logic [DATA_W-1:0] wb_write_code,
  input  logic [DATA_W-1:0] wb_w_data,
  input  logic              ex_load_valid,
  input  logic [RIDX_W-1:0] ex_load_rd,
  input  logic              flush
);

  localparam int   PAD_W  = DATA_W - RIDX_W;
  localparam logic BYP_ON = (BYPASS_EN != 0);

  // Writeback forwarding: the register file commits on the same edge this
  // stage samples, so a matching writeback must replace the stale read data.
  // The compare is against the full writeback code, so codes above 15 never hit.
  function automatic logic [DATA_W-1:0] bypass_sel(
    input logic              wb_en,
    input logic [DATA_W-1:0] wb_code,
    input logic [DATA_W-1:0] wb_data,
    input logic [RIDX_W-1:0] idx,
    input logic [DATA_W-1:0] dflt
  );
    logic [DATA_W-1:0] idx_ext;
    idx_ext = {{PAD_W{1'b0}}, idx};
    if (wb_en && (wb_code == idx_ext)) begin
      bypass_sel = wb_data;
    end else begin
      bypass_sel = dflt;
    end
  endfunction

  logic [RIDX_W-1:0] rs_s, rt_s;
  logic              hazard_s, ready_s, accept_s, byp_en_s;

  logic              out_valid_r, valid_n_s;
  logic [3:0]        opcode_r, opcode_n_s;
  logic [RIDX_W-1:0] rd_r, rd_n_s;
  logic [RIDX_W-1:0] rs_r, rs_n_s;
  logic [RIDX_W-1:0] rt_r, rt_n_s;
  logic [DATA_W-1:0] a_r, a_n_s;
  logic [DATA_W-1:0] b_r, b_n_s;
  logic [DATA_W-1:0] pc_r, pc_n_s;

  assign rs_s     = fetch.in_instr[7:4];
  assign rt_s     = fetch.in_instr[3:0];
  assign rf_reg1  = {{PAD_W{1'b0}}, rs_s};
  assign rf_reg2  = {{PAD_W{1'b0}}, rt_s};
  assign byp_en_s = BYP_ON && wb_w_flag;

  assign hazard_s = ex_load_valid && ((ex_load_rd == rs_s) || (ex_load_rd == rt_s));
  // Ready deliberately ignores in_valid so fetch can use it without a loop.
  assign ready_s  = !flush && !hazard_s && (!out_valid_r || exec.out_ready);
  assign accept_s = fetch.in_valid && ready_s;

  assign fetch.in_ready  = ready_s;
  assign exec.out_valid  = out_valid_r;
  assign exec.out_opcode = opcode_r;
  assign exec.out_rd     = rd_r;
  assign exec.out_a      = a_r;
  assign exec.out_b      = b_r;
  assign exec.out_pc     = pc_r;

  // Next-state of the pipeline register: flush, accept, drain, held refresh.
  always_comb begin
    valid_n_s  = out_valid_r;
    opcode_n_s = opcode_r;
    rd_n_s     = rd_r;
    rs_n_s     = rs_r;
    rt_n_s     = rt_r;
    a_n_s      = a_r;
    b_n_s      = b_r;
    pc_n_s     = pc_r;
    if (flush) begin
      // Data keeps its old (defined) value; only the valid bit is squashed.
      valid_n_s = 1'b0;
    end else if (accept_s) begin
      valid_n_s  = 1'b1;
      opcode_n_s = fetch.in_instr[15:12];
      rd_n_s     = fetch.in_instr[11:8];
      rs_n_s     = rs_s;
      rt_n_s     = rt_s;
      a_n_s      = bypass_sel(byp_en_s, wb_write_code, wb_w_data, rs_s, rf_read1);
      b_n_s      = bypass_sel(byp_en_s, wb_write_code, wb_w_data, rt_s, rf_read2);
      pc_n_s     = fetch.in_pc;
    end else if (out_valid_r && exec.out_ready) begin
      valid_n_s = 1'b0;
    end else if (out_valid_r) begin
      // Stalled by execute: keep held operands current with later writebacks.
      a_n_s = bypass_sel(byp_en_s, wb_write_code, wb_w_data, rs_r, a_r);
      b_n_s = bypass_sel(byp_en_s, wb_write_code, wb_w_data, rt_r, b_r);
    end else begin
      valid_n_s = 1'b0;
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      opcode_r    <= 4'h0;
      rd_r        <= {RIDX_W{1'b0}};
      rs_r        <= {RIDX_W{1'b0}};
      rt_r        <= {RIDX_W{1'b0}};
      a_r         <= {DATA_W{1'b0}};
      b_r         <= {DATA_W{1'b0}};
      pc_r        <= {DATA_W{1'b0}};
    end else begin
      out_valid_r <= valid_n_s;
      opcode_r    <= opcode_n_s;
      rd_r        <= rd_n_s;
      rs_r        <= rs_n_s;
      rt_r        <= rt_n_s;
      a_r         <= a_n_s;
      b_r         <= b_n_s;
      pc_r        <= pc_n_s;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: a combinational vector table,
// hand-written multi-cycle sequences, then randomized traffic against a
// behavioural model of the stage and an array-based register file.

module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] rf_reg1, rf_reg2, rf_read1, rf_read2;
  logic        wb_w_flag;
  logic [15:0] wb_write_code, wb_w_data;
  logic        ex_load_valid;
  logic [3:0]  ex_load_rd;
  logic        flush;
  logic [15:0] rf [16];

  int checks = 0;
  int errors = 0;

  fetch_if #(.DATA_W(16)) f ();
  exec_if  #(.DATA_W(16), .RIDX_W(4)) e ();

  operand_fetch_stage #(.DATA_W(16), .RIDX_W(4), .BYPASS_EN(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch         (f),
    .exec          (e),
    .rf_reg1       (rf_reg1),
    .rf_reg2       (rf_reg2),
    .rf_read1      (rf_read1),
    .rf_read2      (rf_read2),
    .wb_w_flag     (wb_w_flag),
    .wb_write_code (wb_write_code),
    .wb_w_data     (wb_w_data),
    .ex_load_valid (ex_load_valid),
    .ex_load_rd    (ex_load_rd),
    .flush         (flush)
  );

  always #5 clk = ~clk;

  // Register file read ports are combinational from the stage's addresses.
  assign rf_read1 = rf[rf_reg1[3:0]];
  assign rf_read2 = rf[rf_reg2[3:0]];

  // ---------------- behavioural model ----------------
  bit         m_valid;
  bit         m_known;
  logic [3:0] m_op, m_rd, m_rs, m_rt;
  logic [15:0] m_a, m_b, m_pc;

  function automatic logic [15:0] fwd(input logic [3:0] idx, input logic [15:0] v);
    if (wb_w_flag && wb_write_code == {12'h000, idx}) return wb_w_data;
    return v;
  endfunction

  function automatic bit model_ready();
    bit hz;
    hz = ex_load_valid && (ex_load_rd == f.in_instr[7:4] || ex_load_rd == f.in_instr[3:0]);
    return !flush && !hz && (!m_valid || e.out_ready);
  endfunction

  task automatic model_edge();
    bit captured, consumed;
    captured = f.in_valid && model_ready();
    consumed = m_valid && e.out_ready;
    if (reset) begin
      m_valid = 1'b0; m_known = 1'b1;
      m_op = 4'h0; m_rd = 4'h0; m_rs = 4'h0; m_rt = 4'h0;
      m_a = 16'h0; m_b = 16'h0; m_pc = 16'h0;
    end else if (flush) begin
      m_valid = 1'b0; m_known = 1'b0;
    end else if (captured) begin
      m_valid = 1'b1; m_known = 1'b1;
      m_op = f.in_instr[15:12]; m_rd = f.in_instr[11:8];
      m_rs = f.in_instr[7:4];   m_rt = f.in_instr[3:0];
      m_a  = fwd(m_rs, rf[m_rs]); m_b = fwd(m_rt, rf[m_rt]);
      m_pc = f.in_pc;
    end else if (consumed) begin
      m_valid = 1'b0;
    end else if (m_valid) begin
      m_a = fwd(m_rs, m_a); m_b = fwd(m_rt, m_b);
    end
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: model advances on pre-edge inputs, register file commits.
  task automatic step();
    #1;
    model_edge();
    @(posedge clk);
    if (wb_w_flag && wb_write_code < 16'd16) rf[wb_write_code[3:0]] <= wb_w_data;
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // ---------------- combinational vector table ----------------
  typedef struct {
    logic [15:0] instr;
    logic        ld_v;
    logic [3:0]  ld_rd;
    logic        fl;
    logic        exp_rdy;
    logic [15:0] exp_r1;
    logic [15:0] exp_r2;
  } vec_t;

  vec_t vec [8];

  initial begin
    vec[0] = '{16'h2356, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0005, 16'h0006};
    vec[1] = '{16'h0034, 1'b1, 4'h4, 1'b0, 1'b0, 16'h0003, 16'h0004};
    vec[2] = '{16'h0034, 1'b1, 4'h3, 1'b0, 1'b0, 16'h0003, 16'h0004};
    vec[3] = '{16'h0034, 1'b1, 4'h5, 1'b0, 1'b1, 16'h0003, 16'h0004};
    vec[4] = '{16'h0034, 1'b0, 4'h4, 1'b0, 1'b1, 16'h0003, 16'h0004};
    vec[5] = '{16'hF0AB, 1'b0, 4'h0, 1'b1, 1'b0, 16'h000A, 16'h000B};
    vec[6] = '{16'hFFFF, 1'b1, 4'hE, 1'b0, 1'b1, 16'h000F, 16'h000F};
    vec[7] = '{16'h0000, 1'b1, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000};

    for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
    reset = 1'b1; flush = 1'b0;
    f.in_valid = 1'b0; f.in_instr = 16'h0000; f.in_pc = 16'h0000;
    e.out_ready = 1'b1;
    wb_w_flag = 1'b0; wb_write_code = 16'h0000; wb_w_data = 16'h0000;
    ex_load_valid = 1'b0; ex_load_rd = 4'h0;

    // Reset state
    step();
    check("reset_valid", {63'h0, e.out_valid}, 64'h0);
    check("reset_data", {e.out_opcode, e.out_rd, e.out_a, e.out_b, e.out_pc}, 64'h0);
    reset = 1'b0;

    // Table: out_valid=0, in_valid=0, so only combinational outputs move.
    for (int i = 0; i < 8; i++) begin
      f.in_instr = vec[i].instr; ex_load_valid = vec[i].ld_v;
      ex_load_rd = vec[i].ld_rd; flush = vec[i].fl;
      settle();
      check($sformatf("tbl%0d_ready", i), {63'h0, f.in_ready}, {63'h0, vec[i].exp_rdy});
      check($sformatf("tbl%0d_regs", i), {32'h0, rf_reg1, rf_reg2}, {32'h0, vec[i].exp_r1, vec[i].exp_r2});
    end
    ex_load_valid = 1'b0; flush = 1'b0;

    // Plain accept
    rf[5] <= 16'h00AA; rf[6] <= 16'h0055;
    f.in_instr = 16'h2356; f.in_pc = 16'h0010; f.in_valid = 1'b1; e.out_ready = 1'b1;
    settle();
    check("plain_ready", {63'h0, f.in_ready}, 64'h1);
    step();
    check("plain_out", {3'h0, e.out_valid, e.out_opcode, e.out_rd, e.out_a, e.out_b, e.out_pc},
          {3'h0, 1'b1, 4'h2, 4'h3, 16'h00AA, 16'h0055, 16'h0010});

    // Same-cycle writeback, rs==rt
    rf[5] <= 16'h0001;
    f.in_instr = 16'h1255; f.in_pc = 16'h0011;
    wb_w_flag = 1'b1; wb_write_code = 16'h0005; wb_w_data = 16'hBEEF;
    step();
    check("wb_same_cycle", {e.out_opcode, e.out_rd, e.out_a, e.out_b, e.out_pc},
          {4'h1, 4'h2, 16'hBEEF, 16'hBEEF, 16'h0011});
    wb_w_flag = 1'b0;

    // Back-pressure with held refresh
    rf[7] <= 16'h7777; rf[8] <= 16'h8888;
    f.in_instr = 16'h3478; f.in_pc = 16'h0020;
    step();
    e.out_ready = 1'b0; f.in_instr = 16'h4100; f.in_pc = 16'h0030;
    wb_w_flag = 1'b1; wb_write_code = 16'h0008; wb_w_data = 16'h1357;
    settle();
    check("bp_ready", {63'h0, f.in_ready}, 64'h0);
    step();
    check("bp_refresh", {3'h0, e.out_valid, e.out_opcode, e.out_a, e.out_b, e.out_pc},
          {3'h0, 1'b1, 4'h3, 16'h7777, 16'h1357, 16'h0020});
    wb_w_flag = 1'b0; e.out_ready = 1'b1; f.in_valid = 1'b0;
    step();
    check("bp_drain", {63'h0, e.out_valid}, 64'h0);

    // Reset mid-operation
    f.in_valid = 1'b1; f.in_instr = 16'h1234; f.in_pc = 16'h0ABC; e.out_ready = 1'b0;
    step();
    check("mid_hold", {3'h0, e.out_valid, e.out_pc}, {3'h0, 1'b1, 16'h0ABC});
    reset = 1'b1; f.in_valid = 1'b0;
    step();
    check("mid_reset", {15'h0, e.out_valid, e.out_a, e.out_b, e.out_pc}, 64'h0);
    reset = 1'b0;
    settle();
    check("mid_ready", {63'h0, f.in_ready}, 64'h1);

    // Load-use stall
    e.out_ready = 1'b1; ex_load_valid = 1'b1; ex_load_rd = 4'h4;
    f.in_valid = 1'b1; f.in_instr = 16'h5014; f.in_pc = 16'h0050;
    settle();
    check("lu_ready", {63'h0, f.in_ready}, 64'h0);
    step();
    check("lu_nocap", {63'h0, e.out_valid}, 64'h0);
    ex_load_valid = 1'b0;
    settle();
    check("lu_release", {63'h0, f.in_ready}, 64'h1);
    step();
    check("lu_cap", {11'h0, e.out_valid, e.out_opcode, e.out_rd, e.out_pc},
          {11'h0, 1'b1, 4'h5, 4'h0, 16'h0050});

    // Flush priority, then back-to-back throughput
    flush = 1'b1; f.in_instr = 16'h6ABC; f.in_pc = 16'h0040;
    settle();
    check("fl_ready", {63'h0, f.in_ready}, 64'h0);
    step();
    check("fl_valid", {63'h0, e.out_valid}, 64'h0);
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      f.in_instr = {4'(k + 7), 4'h1, 4'(k), 4'(k + 1)}; f.in_pc = 16'(16'h0100 + k);
      settle();
      check($sformatf("b2b%0d_ready", k), {63'h0, f.in_ready}, 64'h1);
      step();
      check($sformatf("b2b%0d_out", k), {43'h0, e.out_valid, e.out_opcode, e.out_pc},
            {43'h0, 1'b1, 4'(k + 7), 16'(16'h0100 + k)});
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 11) == 0);
      f.in_valid = ($urandom_range(0, 3) != 0);
      f.in_instr = 16'($urandom);
      if ($urandom_range(0, 1) == 1) f.in_instr[7:0] = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      f.in_pc = 16'($urandom);
      e.out_ready = ($urandom_range(0, 9) < 7);
      wb_w_flag = ($urandom_range(0, 1) == 1);
      wb_write_code = ($urandom_range(0, 7) == 0) ?
                      {8'($urandom_range(1, 255)), 8'($urandom_range(0, 3))} :
                      16'($urandom_range(0, 17));
      wb_w_data = 16'($urandom);
      ex_load_valid = ($urandom_range(0, 3) == 0);
      ex_load_rd = 4'($urandom_range(0, 3));
      settle();
      check("rnd_ready", {63'h0, f.in_ready}, {63'h0, model_ready()});
      check("rnd_regs", {32'h0, rf_reg1, rf_reg2}, {44'h0, f.in_instr[7:4], 12'h000, f.in_instr[3:0]});
      step();
      check("rnd_valid", {63'h0, e.out_valid}, {63'h0, m_valid});
      if (m_known)
        check("rnd_data", {e.out_opcode, e.out_rd, e.out_a, e.out_b, e.out_pc},
              {m_op, m_rd, m_a, m_b, m_pc});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode/operand-fetch pipeline stage directly upstream of the 16x16 register file.
- Takes fetched 16-bit instructions and drives the register file read addresses.
- Captures both read operands, with a writeback bypass, into a one-entry valid/ready pipeline register that feeds execute.
- Detects load-use hazards and back-pressures fetch.

Parameters:
- DATA_W, 16, operand/instruction/PC width
- RIDX_W, 4, register index width (16 registers)
- BYPASS_EN, 1, 1 enables writeback bypass and held-operand refresh; 0 disables both

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  16  instruction: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt
- in_pc  in  16  instruction PC
- rf_reg1  out  16  register file read address 1 = zero-extended in_instr[7:4]
- rf_reg2  out  16  register file read address 2 = zero-extended in_instr[3:0]
- rf_read1  in  16  register file read data 1 (combinational)
- rf_read2  in  16  register file read data 2
- wb_w_flag  in  1  writeback enable (same net as register file write enable)
- wb_write_code  in  16  writeback register index
- wb_w_data  in  16  writeback data
- ex_load_valid  in  1  execute stage holds a load
- ex_load_rd  in  4  destination of that load
- flush  in  1  squash held and incoming instruction
- out_valid  out  1  output register holds an instruction
- out_ready  in  1  execute consumes
- out_opcode  out  4  latched opcode
- out_rd  out  4  latched rd
- out_a  out  16  operand for rs
- out_b  out  16  operand for rt
- out_pc  out  16  latched PC

Behaviour:
- **Reset:** On a clock edge with reset=1, out_valid=0 and out_opcode/out_rd/out_a/out_b/out_pc=0. Reset overrides flush, accept and refresh.
- **Read addresses:** rf_reg1 and rf_reg2 are purely combinational from in_instr, upper 12 bits zero. They are driven regardless of in_valid.
- **Hazard:** hazard = ex_load_valid && (ex_load_rd==in_instr[7:4] || ex_load_rd==in_instr[3:0]).
- **Ready:** in_ready = !flush && !hazard && (!out_valid || out_ready). Combinational; no dependence on in_valid.
- **Accept** (in_valid && in_ready):
  - Next edge: out_valid=1; opcode, rd and pc are latched.
  - out_a = bypass(rs, rf_read1); out_b = bypass(rt, rf_read2).
- **Bypass rule:** bypass(i, d) = wb_w_data if BYPASS_EN && wb_w_flag && wb_write_code==i (full 16-bit compare, upper bits zero); otherwise d.
  - Required because the register file commits on the same edge the stage samples.
  - rs==rt bypasses both operands.
- **Drain:** out_valid && out_ready && no accept gives out_valid=0 next edge. Data registers hold their values.
- **Held refresh** (BYPASS_EN=1): while out_valid && !out_ready with no accept, a writeback matching latched rs updates out_a, and one matching latched rt updates out_b. The stage therefore latches rs and rt internally.
- **Flush:** out_valid=0 next edge and no accept that cycle (in_ready=0). Data registers are don't-care but must not go X.
- **Load-use stall:** no bubble register is required. out_valid simply drops after drain while in_ready=0.
- **Throughput:** one instruction per cycle when out_ready=1 and no hazard.
- **Latency:** one cycle from accept to out_valid.
- **wb_write_code outside 0..15:** never matches; no bypass.

Test Plan:
- Reset mid-operation: out_valid=1 holding instr 0x1234, assert reset one cycle -> out_valid=0, out_a=out_b=out_pc=0. in_ready=1 the following cycle if no hazard.
- Plain accept: R5=0x00AA, R6=0x0055, instr 0x2356, pc 0x0010, out_ready=1 -> next cycle out_opcode=2, out_rd=3, out_a=0x00AA, out_b=0x0055, out_pc=0x0010. rf_reg1=0x0005, rf_reg2=0x0006.
- Same-cycle writeback: accept instr 0x1255 while wb writes R5=0xBEEF, and the register file still reads the old value 0x0001 -> out_a=out_b=0xBEEF.
- Back-pressure with refresh: hold out_ready=0 after accepting rs=R7 and rt=R8, then writeback R8=0x1357 -> out_b becomes 0x1357 next cycle, out_a unchanged, in_ready=0. Release out_ready -> out_valid drops unless a new accept occurs.
- Load-use: ex_load_valid=1, ex_load_rd=4, in_instr rt=4 -> in_ready=0 and no capture. Deassert ex_load_valid -> accept next cycle.
- Flush priority: flush=1 with in_valid=1 and out_valid=1 -> in_ready=0, out_valid=0 next edge, incoming instruction not captured. Back-to-back accepts at out_ready=1 afterwards -> one instruction per cycle.
